fx_kpc: RTL and testbench

FX_KPC -- requirements
Module: fx_kpc

---
 rtl/fx_kpc.sv | 172 +++++++++++++++++
 tb/tb_fx_kpc.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fx_kpc.sv
// Keypad/pad serial controller: optional latch pulse, then NBITS clocked bits (LSB first).
// Define FX_KPC_INT_EN to build INTKP as a one-cycle-delayed copy of END.
module fx_kpc #(
    parameter int HALF_DIV = 8,
    parameter int NBITS    = 32
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic        TRG,
    input  logic        MOD,
    input  logic        IOS,
    input  logic [31:0] TXD,
    input  logic        RD_ACK,
    output logic [31:0] RXD,
    output logic        BUSY,
    output logic        END,
    output logic        INTKP,
    output logic        KP_CLK,
    output logic        KP_LATCH,
    output logic        KP_DO,
    input  logic        KP_DI
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_CLKLO = 3'd2,
        ST_CLKHI = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(HALF_DIV - 1);
    localparam logic [5:0] NBITS_C    = 6'(NBITS);

    state_t      state_r;
    logic [7:0]  div_r;
    logic        latch_ph_r;
    logic [5:0]  bitcnt_r;
    logic [31:0] shift_r;
    logic [31:0] rxd_r;
    logic        busy_r;
    logic        end_r;
    logic        kp_clk_r;
    logic        kp_latch_r;
    logic        kp_do_r;
    logic        div_zero_s;
    logic [5:0]  next_bit_s;

    assign div_zero_s = (div_r == 8'd0);
    assign next_bit_s = bitcnt_r + 6'd1;

    // Transfer sequencer: phase timing, shifting, sampling and status flags.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_r    <= ST_IDLE;
            div_r      <= 8'd0;
            latch_ph_r <= 1'b0;
            bitcnt_r   <= 6'd0;
            shift_r    <= 32'd0;
            rxd_r      <= 32'd0;
            busy_r     <= 1'b0;
            end_r      <= 1'b0;
            kp_clk_r   <= 1'b1;
            kp_latch_r <= 1'b0;
            kp_do_r    <= 1'b0;
        end else if (CE) begin
            // Later assignments in DONE / IDLE-with-TRG override the read acknowledge.
            if (RD_ACK) begin
                end_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (TRG) begin
                        shift_r    <= TXD;
                        bitcnt_r   <= 6'd0;
                        busy_r     <= 1'b1;
                        end_r      <= 1'b0;
                        div_r      <= DIV_RELOAD;
                        latch_ph_r <= 1'b0;
                        if (MOD) begin
                            state_r    <= ST_LATCH;
                            kp_latch_r <= 1'b1;
                        end else begin
                            state_r  <= ST_CLKLO;
                            kp_clk_r <= 1'b0;
                            kp_do_r  <= IOS ? 1'b0 : TXD[0];
                        end
                    end
                end
                ST_LATCH: begin
                    // Latch spans two half-periods so the 8-bit divider never overflows.
                    if (div_zero_s) begin
                        div_r <= DIV_RELOAD;
                        if (latch_ph_r) begin
                            latch_ph_r <= 1'b0;
                            kp_latch_r <= 1'b0;
                            state_r    <= ST_CLKLO;
                            kp_clk_r   <= 1'b0;
                            kp_do_r    <= IOS ? 1'b0 : shift_r[0];
                        end else begin
                            latch_ph_r <= 1'b1;
                        end
                    end else begin
                        div_r <= div_r - 8'd1;
                    end
                end
                ST_CLKLO: begin
                    if (div_zero_s) begin
                        state_r                <= ST_CLKHI;
                        div_r                  <= DIV_RELOAD;
                        kp_clk_r               <= 1'b1;
                        rxd_r[bitcnt_r[4:0]]   <= KP_DI;
                    end else begin
                        div_r <= div_r - 8'd1;
                    end
                end
                ST_CLKHI: begin
                    if (div_zero_s) begin
                        bitcnt_r <= next_bit_s;
                        shift_r  <= shift_r >> 1;
                        div_r    <= DIV_RELOAD;
                        if (next_bit_s < NBITS_C) begin
                            state_r  <= ST_CLKLO;
                            kp_clk_r <= 1'b0;
                            kp_do_r  <= IOS ? 1'b0 : shift_r[1];
                        end else begin
                            state_r <= ST_DONE;
                            kp_do_r <= 1'b0;
                        end
                    end else begin
                        div_r <= div_r - 8'd1;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    end_r   <= 1'b1;
                    div_r   <= DIV_RELOAD;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FX_KPC_INT_EN
    logic intkp_r;

    // Interrupt request trails END by one enabled cycle.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            intkp_r <= 1'b0;
        end else if (CE) begin
            intkp_r <= end_r;
        end
    end

    assign INTKP = intkp_r;
`else
    assign INTKP = 1'b0;
`endif

    assign RXD      = rxd_r;
    assign BUSY     = busy_r;
    assign END      = end_r;
    assign KP_CLK   = kp_clk_r;
    assign KP_LATCH = kp_latch_r;
    assign KP_DO    = kp_do_r;

endmodule

// File: tb/tb_fx_kpc.sv
// Scoreboard bench for fx_kpc: a 32-bit and a 4-bit instance, HALF_DIV=2.
module tb_fx_kpc;

    localparam int HD = 2;
`ifdef FX_KPC_INT_EN
    localparam logic INT_EN = 1'b1;
`else
    localparam logic INT_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] rxd;
        int          len;
    } exp_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        ce     = 1'b1;
    logic        trg32  = 1'b0;
    logic        trg4   = 1'b0;
    logic        mod    = 1'b0;
    logic        ios    = 1'b0;
    logic        rd_ack = 1'b0;
    logic        kp_di  = 1'b0;
    logic [31:0] txd    = 32'd0;
    logic        sel4   = 1'b0;

    logic [31:0] rxd32, rxd4;
    logic busy32, end32, int32, kpclk32, kplat32, kpdo32;
    logic busy4, end4, int4, kpclk4, kplat4, kpdo4;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    logic [31:0] pat_r = 32'd0;
    int          pulses, falls, latch_cyc, do_hi;
    logic [31:0] do_seq;
    logic        kc_prev = 1'b1;

    wire [31:0] rxd_s   = sel4 ? rxd4   : rxd32;
    wire        busy_s  = sel4 ? busy4  : busy32;
    wire        end_s   = sel4 ? end4   : end32;
    wire        intkp_s = sel4 ? int4   : int32;
    wire        kpclk_s = sel4 ? kpclk4 : kpclk32;
    wire        kplat_s = sel4 ? kplat4 : kplat32;
    wire        kpdo_s  = sel4 ? kpdo4  : kpdo32;

    always #5 clk = ~clk;

    fx_kpc #(.HALF_DIV(HD), .NBITS(32)) dut32 (
        .CLK(clk), .RESn(rst_n), .CE(ce), .TRG(trg32), .MOD(mod), .IOS(ios),
        .TXD(txd), .RD_ACK(rd_ack), .RXD(rxd32), .BUSY(busy32), .END(end32),
        .INTKP(int32), .KP_CLK(kpclk32), .KP_LATCH(kplat32), .KP_DO(kpdo32),
        .KP_DI(kp_di)
    );

    fx_kpc #(.HALF_DIV(HD), .NBITS(4)) dut4 (
        .CLK(clk), .RESn(rst_n), .CE(ce), .TRG(trg4), .MOD(mod), .IOS(ios),
        .TXD(txd), .RD_ACK(rd_ack), .RXD(rxd4), .BUSY(busy4), .END(end4),
        .INTKP(int4), .KP_CLK(kpclk4), .KP_LATCH(kplat4), .KP_DO(kpdo4),
        .KP_DI(kp_di)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Called once per negedge: tracks pad activity and feeds the next KP_DI bit after each rise.
    task automatic sample_pads();
        logic kc;
        kc = kpclk_s;
        if (kplat_s) latch_cyc++;
        if (ios && kpdo_s) do_hi++;
        if (!kc_prev && kc) begin
            pulses++;
            kp_di = pat_r[pulses % 32];
        end
        if (kc_prev && !kc) begin
            if (falls < 32) do_seq[falls] = kpdo_s;
            falls++;
        end
        kc_prev = kc;
    endtask

    task automatic start_xfer(input logic use4, input logic [31:0] pat, input logic [31:0] tx,
                              input logic m, input logic io);
        @(negedge clk);
        sel4 = use4; pat_r = pat; txd = tx; mod = m; ios = io; ce = 1'b1;
        pulses = 0; falls = 0; latch_cyc = 0; do_hi = 0; do_seq = 32'd0;
        kc_prev = 1'b1; kp_di = pat[0];
        if (use4) trg4 = 1'b1; else trg32 = 1'b1;
        @(negedge clk);
        trg4 = 1'b0; trg32 = 1'b0;
        sample_pads();
    endtask

    task automatic run_xfer(input logic use4, input logic [31:0] pat, input logic [31:0] tx,
                            input logic m, input logic io, input logic ce_tog,
                            input logic retrig, input logic ack_done);
        exp_t e;
        int   nb, n;
        logic got, rt_done;
        nb    = use4 ? 4 : 32;
        e.len = ((m ? 2 : 0) * HD + 2 * nb * HD + 1) * (ce_tog ? 2 : 1);
        e.rxd = use4 ? (pat & 32'h0000_000F) : pat;
        sb.push_back(e);
        start_xfer(use4, pat, tx, m, io);
        check_eq("end_clr_on_trg", {31'd0, end_s}, 32'd0);
        check_eq("busy_set", {31'd0, busy_s}, 32'd1);
        n = 0; got = 1'b0; rt_done = 1'b0;
        while (!got && n < e.len + 40) begin
            if (ce_tog) ce = ~ce;
            rd_ack = ack_done && (n == e.len - 1);
            if (retrig && !rt_done && pulses == 10) begin
                trg32 = 1'b1; rt_done = 1'b1;
            end else begin
                trg32 = 1'b0;
            end
            @(negedge clk);
            n++;
            sample_pads();
            if (end_s) got = 1'b1;
        end
        rd_ack = 1'b0; trg32 = 1'b0; ce = 1'b1;
        e = sb.pop_front();
        check_eq("xfer_len", n, e.len);
        check_eq("rxd", rxd_s, e.rxd);
        check_eq("clk_pulses", pulses, nb);
        check_eq("busy_clr", {31'd0, busy_s}, 32'd0);
        if (!ce_tog) check_eq("latch_cycles", latch_cyc, m ? 2 * HD : 0);
        if (io) check_eq("do_quiet_rx", do_hi, 32'd0);
        else    check_eq("do_seq", do_seq & ((32'd1 << nb) - 32'd1), tx & ((32'd1 << nb) - 32'd1));
        if (ack_done) begin
            check_eq("end_wins_over_ack", {31'd0, end_s}, 32'd1);
            check_eq("intkp_lag_rise", {31'd0, intkp_s}, 32'd0);
            rd_ack = 1'b1;
            @(negedge clk);
            rd_ack = 1'b0;
            check_eq("end_ack_clr", {31'd0, end_s}, 32'd0);
            check_eq("intkp_hold", {31'd0, intkp_s}, {31'd0, INT_EN});
            @(negedge clk);
            check_eq("intkp_clr", {31'd0, intkp_s}, 32'd0);
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy32}, 32'd0);
        check_eq("rst_end", {31'd0, end32}, 32'd0);
        check_eq("rst_intkp", {31'd0, int32}, 32'd0);
        check_eq("rst_rxd", rxd32, 32'd0);
        check_eq("rst_pads", {29'd0, kpclk32, kplat32, kpdo32}, 32'd4);
        rst_n = 1'b1;
        @(negedge clk);

        run_xfer(1'b0, 32'hA5C3_0F81, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_xfer(1'b1, 32'h0000_0009, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_xfer(1'b0, 32'hA5C3_0F81, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        run_xfer(1'b0, 32'hA5C3_0F81, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_xfer(1'b0, 32'h1234_5678, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        run_xfer(1'b0, 32'h0F0F_3355, 32'h8000_00AC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort during the high phase of bit 5.
        start_xfer(1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
        n = 0;
        while (pulses < 6 && n < 200) begin
            @(negedge clk);
            n++;
            sample_pads();
        end
        check_eq("reach_bit5", pulses, 32'd6);
        rst_n = 1'b0;
        #1;
        check_eq("abort_kpclk", {31'd0, kpclk32}, 32'd1);
        check_eq("abort_busy", {31'd0, busy32}, 32'd0);
        check_eq("abort_end", {31'd0, end32}, 32'd0);
        check_eq("abort_rxd", rxd32, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("no_end_after_abort", {31'd0, end32}, 32'd0);
        run_xfer(1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
